// File: rtl/start_screen_pkg.sv
// rtl/start_screen_pkg.sv - shared start-screen types, layout constants and band helper
//
// Contents:
//   state_t       start-screen sequencer states
//   rgb12_t       12-bit {R4,G4,B4} pixel colour
//   TITLE_Y/H     title text band rows (shared with the text renderer)
//   PRESS_ROW_Y/H "PRESS START" row band (shared with the text renderer)
//   in_band()     row-range test: base <= y < base + height
package start_screen_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        WAIT    = 2'd1,
        CONFIRM = 2'd2,
        PLAY    = 2'd3
    } state_t;

    typedef logic [11:0] rgb12_t;

    localparam logic [9:0] TITLE_Y     = 10'd100;
    localparam logic [9:0] TITLE_H     = 10'd32;
    localparam logic [9:0] PRESS_ROW_Y = 10'd250;
    localparam logic [9:0] PRESS_ROW_H = 10'd16;

    function automatic logic in_band(input logic [9:0] row,
                                     input logic [9:0] base,
                                     input logic [9:0] height);
        return (row >= base) && (row < (base + height));
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop button synchroniser with rising-edge pulse
//
// Ports:
//   clk        in   pixel clock
//   rst_n      in   synchronous active-low reset
//   btn        in   raw asynchronous button, active-high
//   btn_s      out  synchronised button level
//   press_edge out  one-cycle pulse when btn_s rises
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_s,
    output logic press_edge
);

    logic sync_1;
    logic btn_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1   <= 1'b0;
            btn_s    <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            sync_1   <= btn;
            btn_s    <= sync_1;
            btn_prev <= btn_s;
        end
    end

    assign press_edge = btn_s & ~btn_prev;

endmodule

// File: rtl/start_screen_compositor.sv
// rtl/start_screen_compositor.sv - start-screen sequencer, blink timing and text colouring
//
// Ports:
//   clk, rst_n            pixel clock, synchronous active-low reset
//   x, y                  current pixel column / row
//   video_on              active-video qualifier
//   hsync_in, vsync_in    syncs aligned with x/y
//   frame_tick            one pulse per frame (start of vertical blank)
//   text_pixel_on         text mask for (x,y), same cycle as x/y
//   start_btn             raw asynchronous start button
//   return_title          pulse from the game core asking for the start screen
//   rgb                   registered colour, one cycle after x/y
//   hsync_out, vsync_out  syncs delayed one cycle to line up with rgb
//   in_start_screen       high in every state except PLAY
//   game_start            one-cycle pulse on CONFIRM -> PLAY
module start_screen_compositor
    import start_screen_pkg::*;
#(
    parameter int     BLINK_FRAMES   = 30,
    parameter int     FLASH_FRAMES   = 4,
    parameter int     CONFIRM_FRAMES = 60,
    parameter rgb12_t TITLE_RGB      = 12'hFC0,
    parameter rgb12_t TEXT_RGB       = 12'hFFF,
    parameter rgb12_t BG_RGB         = 12'h008
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_tick,
    input  logic        text_pixel_on,
    input  logic        start_btn,
    input  logic        return_title,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        in_start_screen,
    output logic        game_start
);

    localparam int MAX_FRAMES = (BLINK_FRAMES > CONFIRM_FRAMES) ? BLINK_FRAMES : CONFIRM_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST   = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_FRAMES - 1);

    state_t           state;
    logic             blink_vis;
    logic [CNT_W-1:0] blink_cnt;
    logic [CNT_W-1:0] confirm_cnt;

    logic             btn_s;
    logic             press_edge;

    logic [CNT_W-1:0] blink_last;
    logic             blink_wrap;

    rgb12_t           pixel_colour;
    logic             in_press_row;
    logic             in_title_band;

    // Colour depends only on the row bands, so the column is not consumed.
    logic             unused_x;
    assign unused_x = ^x;

    btn_sync_edge u_btn_sync_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (start_btn),
        .btn_s      (btn_s),
        .press_edge (press_edge)
    );

    // The blink period follows the state: slow in WAIT, fast flash in CONFIRM.
    always_comb begin
        blink_last = (state == CONFIRM) ? FLASH_LAST : BLINK_LAST;
        blink_wrap = (blink_cnt == blink_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ARM;
            blink_vis       <= 1'b1;
            blink_cnt       <= '0;
            confirm_cnt     <= '0;
            game_start      <= 1'b0;
            in_start_screen <= 1'b1;
        end else begin
            game_start <= 1'b0;
            case (state)
                ARM: begin
                    // Blink state is held at its start value for the whole of ARM,
                    // so WAIT is always entered with the row visible.
                    blink_cnt   <= '0;
                    blink_vis   <= 1'b1;
                    confirm_cnt <= '0;
                    if (!btn_s) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A press takes priority over a coincident frame tick.
                    if (press_edge) begin
                        state       <= CONFIRM;
                        blink_cnt   <= '0;
                        confirm_cnt <= '0;
                        blink_vis   <= 1'b1;
                    end else if (frame_tick) begin
                        if (blink_wrap) begin
                            blink_cnt <= '0;
                            blink_vis <= ~blink_vis;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                CONFIRM: begin
                    if (frame_tick) begin
                        if (blink_wrap) begin
                            blink_cnt <= '0;
                            blink_vis <= ~blink_vis;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                        if (confirm_cnt == CONFIRM_LAST) begin
                            state           <= PLAY;
                            game_start      <= 1'b1;
                            in_start_screen <= 1'b0;
                        end else begin
                            confirm_cnt <= confirm_cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (return_title) begin
                        state           <= ARM;
                        in_start_screen <= 1'b1;
                        blink_cnt       <= '0;
                        blink_vis       <= 1'b1;
                        confirm_cnt     <= '0;
                    end
                end
                default: begin
                    state           <= ARM;
                    in_start_screen <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        in_press_row  = in_band(y, PRESS_ROW_Y, PRESS_ROW_H);
        in_title_band = in_band(y, TITLE_Y, TITLE_H);
        pixel_colour  = BG_RGB;
        if (!video_on || state == PLAY) begin
            pixel_colour = '0;
        end else if (text_pixel_on) begin
            if (in_press_row && !blink_vis) begin
                pixel_colour = BG_RGB;
            end else if (in_title_band) begin
                pixel_colour = TITLE_RGB;
            end else begin
                pixel_colour = TEXT_RGB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb       <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb       <= pixel_colour;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

endmodule

// File: tb/tb_start_screen_compositor.sv
// tb/tb_start_screen_compositor.sv - randomized self-checking bench for start_screen_compositor
module tb_start_screen_compositor;

    localparam int M_ARM     = 0;
    localparam int M_WAIT    = 1;
    localparam int M_CONFIRM = 2;
    localparam int M_PLAY    = 3;

    localparam int BLINK     = 30;
    localparam int FLASH     = 4;
    localparam int CONFIRM_N = 60;
    localparam int TICK_GAP  = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        frame_tick;
    logic        text_pixel_on;
    logic        start_btn;
    logic        return_title;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        in_start_screen;
    logic        game_start;

    int n_checks = 0;
    int n_errors = 0;

    int m_state;
    int m_frames;
    bit m_s1, m_s2, m_prev;
    int tick_phase = 0;
    bit directed = 0;
    int gs_seen = 0;

    logic [11:0] e_rgb;
    logic        e_hs, e_vs, e_gs, e_in;

    always #5 clk = ~clk;

    start_screen_compositor #(
        .BLINK_FRAMES   (BLINK),
        .FLASH_FRAMES   (FLASH),
        .CONFIRM_FRAMES (CONFIRM_N),
        .TITLE_RGB      (12'hFC0),
        .TEXT_RGB       (12'hFFF),
        .BG_RGB         (12'h008)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .x               (x),
        .y               (y),
        .video_on        (video_on),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .frame_tick      (frame_tick),
        .text_pixel_on   (text_pixel_on),
        .start_btn       (start_btn),
        .return_title    (return_title),
        .rgb             (rgb),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .in_start_screen (in_start_screen),
        .game_start      (game_start)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Visibility is the parity of how many whole blink periods have elapsed
    // since the state was entered.
    function automatic bit model_vis();
        if (m_state == M_WAIT)    return ((m_frames / BLINK) % 2) == 0;
        if (m_state == M_CONFIRM) return ((m_frames / FLASH) % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [11:0] colour(bit vid, int st, bit vis, int row, bit txt);
        bit press_row, title_row;
        press_row = (row >= 250) && (row < 266);
        title_row = (row >= 100) && (row < 132);
        if (!vid || st == M_PLAY) return 12'h000;
        if (!txt) return 12'h008;
        if (press_row && !vis) return 12'h008;
        if (title_row) return 12'hFC0;
        return 12'hFFF;
    endfunction

    task automatic set_pixel();
        int pick;
        if (directed) begin
            x = 10'd230; y = 10'd252; text_pixel_on = 1'b1; video_on = 1'b1;
        end else begin
            x = 10'($urandom_range(0, 799));
            pick = $urandom_range(0, 3);
            if (pick == 0)      y = 10'($urandom_range(96, 135));
            else if (pick == 1) y = 10'($urandom_range(246, 269));
            else                y = 10'($urandom_range(0, 524));
            text_pixel_on = 1'($urandom_range(0, 1));
            video_on      = ($urandom_range(0, 7) != 0);
        end
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
    endtask

    // One clock: drive inputs, predict the post-edge outputs, then compare.
    task automatic step();
        bit edge_seen;
        int nstate;
        set_pixel();
        frame_tick = (tick_phase == 0);
        tick_phase = (tick_phase + 1) % TICK_GAP;
        if (!rst_n) begin
            e_rgb = 12'h000; e_hs = 1'b0; e_vs = 1'b0; e_gs = 1'b0; e_in = 1'b1;
            m_state = M_ARM; m_frames = 0;
            m_s1 = 0; m_s2 = 0; m_prev = 0;
        end else begin
            e_hs  = hsync_in;
            e_vs  = vsync_in;
            e_rgb = colour(video_on, m_state, model_vis(), int'(y), text_pixel_on);
            e_gs  = 1'b0;
            edge_seen = m_s2 && !m_prev;
            nstate = m_state;
            case (m_state)
                M_ARM: if (!m_s2) begin nstate = M_WAIT; m_frames = 0; end
                M_WAIT: begin
                    if (edge_seen) begin nstate = M_CONFIRM; m_frames = 0; end
                    else if (frame_tick) m_frames++;
                end
                M_CONFIRM: if (frame_tick) begin
                    m_frames++;
                    if (m_frames == CONFIRM_N) begin nstate = M_PLAY; e_gs = 1'b1; m_frames = 0; end
                end
                default: if (return_title) begin nstate = M_ARM; m_frames = 0; end
            endcase
            m_state = nstate;
            e_in = (m_state != M_PLAY);
            m_prev = m_s2; m_s2 = m_s1; m_s1 = start_btn;
        end
        @(posedge clk);
        #1;
        check("rgb", 32'(rgb), 32'(e_rgb));
        check("hsync_out", 32'(hsync_out), 32'(e_hs));
        check("vsync_out", 32'(vsync_out), 32'(e_vs));
        check("game_start", 32'(game_start), 32'(e_gs));
        check("in_start_screen", 32'(in_start_screen), 32'(e_in));
        if (game_start) gs_seen++;
        return_title = 1'b0;
    endtask

    task automatic run_until(input int st, input int frames, input int budget, input string tag);
        int n = 0;
        while (!(m_state == st && (frames < 0 || m_frames == frames)) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(m_state == st), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start_btn = 1'b0; return_title = 1'b0;
        x = '0; y = '0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        frame_tick = 1'b0; text_pixel_on = 1'b0;

        repeat (3) step();
        rst_n = 1'b1;
        run_until(M_WAIT, -1, 4, "arm_to_wait");

        // WAIT: press-row text pixel blinking over 60+ frames.
        directed = 1;
        repeat (61 * TICK_GAP + 3) step();
        directed = 0;
        repeat (120) begin
            if ($urandom_range(0, 39) == 0) return_title = 1'b1;
            step();
        end

        // Press, then ignore button activity during CONFIRM.
        start_btn = 1'b1;
        run_until(M_CONFIRM, -1, 10, "wait_to_confirm");
        begin
            int n = 0;
            while (m_state != M_PLAY && n < 1000) begin
                start_btn = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 29) == 0) return_title = 1'b1;
                step();
                n++;
            end
        end
        check("reach_play", 32'(m_state == M_PLAY), 32'd1);
        check("game_start_count", 32'(gs_seen), 32'd1);
        repeat (20) step();

        // Return with the button held: ARM must wait for release.
        start_btn = 1'b1;
        repeat (6) step();
        return_title = 1'b1;
        step();
        repeat (30) step();
        check("held_in_arm", 32'(m_state == M_ARM), 32'd1);
        start_btn = 1'b0;
        run_until(M_WAIT, -1, 6, "release_to_wait");
        directed = 1;
        repeat (40) step();
        directed = 0;

        // Reset in the middle of CONFIRM: no game_start may appear.
        start_btn = 1'b1;
        run_until(M_CONFIRM, -1, 10, "confirm_again");
        start_btn = 1'b0;
        run_until(M_CONFIRM, 30, 400, "confirm_frame30");
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (60) step();
        check("no_start_after_reset", 32'(gs_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
